data_mem_ctrl: RTL
==================

# data_mem_ctrl

Multi-cycle data-memory controller attached to the memory stage of the 5-stage RV32I pipeline. It owns the data SRAM array and executes one load or store per memory-stage instruction, with byte, half and word sizing. While the fixed-latency array access is in flight it holds `StallM` high to freeze the pipeline. Load results are returned sign- or zero-extended, ready for the MEM/WB register.

## Interface
- `ADDR_W`, default 10: word-address bits, giving 2^ADDR_W 32-bit words.
- `LATENCY`, default 2: array access cycles, legal range 1..7.

- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `MemReadM`, in, 1: load request from the memory stage.
- `MemWriteM`, in, 1: store request from the memory stage.
- `Funct3M`, in, 3: access size. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `AddrM`, in, 32: byte address from the ALU.
- `WriteDataM`, in, 32: store data, right-aligned.
- `StallM`, out, 1: freezes the IF through MEM stages.
- `ReadDataW`, out, 32: extended load result.
- `ReadValidW`, out, 1: `ReadDataW` is valid this cycle.
- `AccessFaultM`, out, 1: misaligned address or illegal `Funct3M`.

## Operation
- FSM states are IDLE, WAIT and DONE. Reset state is IDLE.
- A request is `MemReadM | MemWriteM`. If both are high, the access is treated as a store.
- **Fault:**
  - Fault conditions: `Funct3M` is 3, 6 or 7; a halfword access with `AddrM[0]`=1; a word access with `AddrM[1:0]`≠0. Store `Funct3M`≥3 also faults.
  - On a fault, `AccessFaultM`=1 combinationally in IDLE.
  - No state change, no array write, `StallM`=0, `ReadValidW`=0.
- **Accept (IDLE, legal request):**
  - Latch the word index `AddrM[ADDR_W+1:2]`, byte offset, `Funct3M`, write data and read/write type.
  - Counter `cnt` ← `LATENCY`−1. Go to WAIT.
  - Address bits above `ADDR_W+1` are ignored, so addresses wrap modulo the array size.
- **WAIT:**
  - When `cnt`=0, go to DONE; otherwise decrement `cnt`.
  - On the WAIT→DONE edge: a load captures the array word into a data register; a store writes the array with byte enables.
  - Store byte enables: SB enables the byte at the offset, taking `WriteDataM[7:0]`. SH enables bytes offset and offset+1, taking `[15:0]`. SW enables all 4 bytes.
- **DONE:**
  - Lasts one cycle, then returns to IDLE unconditionally.
  - Requests present in DONE belong to the completing instruction and are ignored.
- **Load extraction:**
  - The byte or halfword is selected by the latched offset.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- **Output values:**
  - `StallM` = (IDLE & legal request) | WAIT.
  - `ReadValidW`=1 only in DONE for a load. `ReadDataW` is 0 whenever `ReadValidW`=0.
- **Reset:**
  - While `reset`=0, the FSM is forced to IDLE, `cnt`=0, and the data register is cleared.
  - An in-flight store not yet written is dropped.
  - Array contents are not cleared.
  - Reset values: `StallM`=0, `ReadValidW`=0, `ReadDataW`=0, `AccessFaultM`=0.

## Timing
- Latency from the accept cycle to DONE is `LATENCY`+1 cycles.
- `StallM` is high for exactly `LATENCY`+1 cycles per access, covering the accept cycle and the WAIT cycles.
- The pipeline advances on the edge that ends DONE.
- `StallM` and `AccessFaultM` are combinational from the inputs and state. There is no combinational path from the array to the outputs.
- A store followed immediately by a load to the same word returns the new data, because the write completes before the load is accepted.

## Configuration
- Macro: `DMEM_READ_BUFFER_EN`.
- **Defined:** a one-entry buffer holds {valid, word index, data}.
  - Filled by every completed load, and updated by every completed store to the same index, with byte merging.
  - Invalidated by reset.
  - A legal load in IDLE whose index matches a valid buffer entry is a hit. On a hit: `StallM`=0, `ReadValidW`=1, `ReadDataW` is extracted from the buffer in the same cycle, and the FSM stays in IDLE.
- **Undefined:** no buffer is built, and every access takes the full FSM path.

## Test plan
- Reset, then SW of 0xDEADBEEF to 0x40 followed by LW from 0x40, with `LATENCY`=2: `StallM` high for 3 cycles per access, LW gives `ReadValidW` in DONE with 0xDEADBEEF.
- SB of 0x80 to 0x41, then LB and LBU from 0x41: 0xFFFFFF80 and 0x00000080; LW from 0x40 gives 0xDEAD80EF.
- LH from 0x43 and SW to 0x42: `AccessFaultM`=1, `StallM`=0, and a later LW from 0x40 is unchanged.
- Assert `reset` during WAIT of an SW of 0x12345678 to 0x80: outputs are 0, the FSM is in IDLE, and a later LW from 0x80 returns the old value.
- `MemReadM` and `MemWriteM` both high with SW of 0xA5A5A5A5 to 0x10: treated as a store, `ReadValidW` stays 0, and a later LW returns 0xA5A5A5A5.
- With `DMEM_READ_BUFFER_EN`: a second LW from 0x40 hits with 0 stall cycles and `ReadValidW` in the same cycle; after an SH of 0x1234 to 0x40, the next LW hits with 0xDEAD1234.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Memory-stage bus between the RV32I pipeline and data_mem_ctrl.
// The pipeline drives requests (master); the controller answers with stall, data and fault (slave).
interface data_mem_ctrl_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataW;
  logic        ReadValidW;
  logic        AccessFaultM;

  modport master (
    output MemReadM, MemWriteM, Funct3M, AddrM, WriteDataM,
    input  StallM, ReadDataW, ReadValidW, AccessFaultM
  );

  modport slave (
    input  MemReadM, MemWriteM, Funct3M, AddrM, WriteDataM,
    output StallM, ReadDataW, ReadValidW, AccessFaultM
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle RV32I data-memory controller: sized loads/stores over a fixed-latency SRAM array.
// Optional one-entry read buffer with same-cycle load hits: define DMEM_READ_BUFFER_EN.
module data_mem_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_ctrl_if.slave bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Select and extend the addressed byte/halfword of a word.
  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = word;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] storeEnables(input logic [1:0] off, input logic [2:0] f3);
    logic [3:0] r;
    case (f3[1:0])
      2'd0:    r = 4'b0001 << off;
      2'd1:    r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Replicate store data onto every lane it could land in; enables pick the real ones.
  function automatic logic [31:0] storeLanes(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'd0:    r = {4{wd[7:0]}};
      2'd1:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] lanes,
                                             input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? lanes[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic isLegal(input logic store, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~a[0];
      3'd2:    ok = (a == 2'b00);
      3'd4:    ok = ~store;
      3'd5:    ok = ~store & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [31:0]       mem [DEPTH];

  state_t            state_r;
  logic [2:0]        cnt_r;
  logic [ADDR_W-1:0] idx_r;
  logic [1:0]        off_r;
  logic [2:0]        f3_r;
  logic [31:0]       wdata_r;
  logic              isStore_r;
  logic [31:0]       data_r;

  logic              req_s;
  logic              legal_s;
  logic              idle_s;
  logic              hit_s;
  logic              accept_s;
  logic              commit_s;
  logic [ADDR_W-1:0] reqIdx_s;
  logic [3:0]        be_s;
  logic [31:0]       lanes_s;
  logic [31:0]       hitData_s;
  logic              unusedAddrHi_s;

`ifdef DMEM_READ_BUFFER_EN
  logic              bufValid_r;
  logic [ADDR_W-1:0] bufIdx_r;
  logic [31:0]       bufData_r;
`endif

  assign unusedAddrHi_s = ^bus.AddrM[31:ADDR_W+2];

  // Request decode, buffer hit detection and commit strobe.
  always_comb begin
    idle_s    = (state_r == IDLE);
    req_s     = bus.MemReadM | bus.MemWriteM;
    reqIdx_s  = bus.AddrM[ADDR_W+1:2];
    legal_s   = isLegal(bus.MemWriteM, bus.Funct3M, bus.AddrM[1:0]);
    hit_s     = 1'b0;
    hitData_s = 32'd0;
`ifdef DMEM_READ_BUFFER_EN
    hit_s     = idle_s & req_s & legal_s & ~bus.MemWriteM & bufValid_r & (bufIdx_r == reqIdx_s);
    hitData_s = extractLoad(bufData_r, bus.AddrM[1:0], bus.Funct3M);
`endif
    accept_s  = idle_s & req_s & legal_s & ~hit_s;
    commit_s  = (state_r == WAIT) & (cnt_r == 3'd0);
    be_s      = storeEnables(off_r, f3_r);
    lanes_s   = storeLanes(wdata_r, f3_r);
  end

  // Output drive; everything is held at zero while reset is asserted.
  always_comb begin
    bus.StallM       = 1'b0;
    bus.AccessFaultM = 1'b0;
    bus.ReadValidW   = 1'b0;
    bus.ReadDataW    = 32'd0;
    if (!reset) begin
      bus.StallM       = 1'b0;
      bus.AccessFaultM = 1'b0;
    end else begin
      bus.StallM       = accept_s | (state_r == WAIT);
      bus.AccessFaultM = idle_s & req_s & ~legal_s;
      if ((state_r == DONE) && !isStore_r) begin
        bus.ReadValidW = 1'b1;
        bus.ReadDataW  = extractLoad(data_r, off_r, f3_r);
      end else if (hit_s) begin
        bus.ReadValidW = 1'b1;
        bus.ReadDataW  = hitData_s;
      end else begin
        bus.ReadValidW = 1'b0;
        bus.ReadDataW  = 32'd0;
      end
    end
  end

  // Access sequencer: accept in IDLE, count down in WAIT, present result in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= 3'd0;
      idx_r     <= '0;
      off_r     <= 2'd0;
      f3_r      <= 3'd0;
      wdata_r   <= 32'd0;
      isStore_r <= 1'b0;
      data_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            idx_r     <= reqIdx_s;
            off_r     <= bus.AddrM[1:0];
            f3_r      <= bus.Funct3M;
            wdata_r   <= bus.WriteDataM;
            isStore_r <= bus.MemWriteM;
            cnt_r     <= CNT_INIT;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == 3'd0) begin
            state_r <= DONE;
            if (!isStore_r) begin
              data_r <= mem[idx_r];
            end
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Array write port; contents survive reset, and an aborted store never reaches here.
  always_ff @(posedge clk) begin
    if (commit_s && isStore_r) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_r][8*i +: 8] <= lanes_s[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_READ_BUFFER_EN
  // Read buffer: filled by completed loads, kept coherent by completed stores to its word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bufValid_r <= 1'b0;
      bufIdx_r   <= '0;
      bufData_r  <= 32'd0;
    end else if (commit_s) begin
      if (!isStore_r) begin
        bufValid_r <= 1'b1;
        bufIdx_r   <= idx_r;
        bufData_r  <= mem[idx_r];
      end else if (bufValid_r && (bufIdx_r == idx_r)) begin
        bufData_r <= mergeBytes(bufData_r, lanes_s, be_s);
      end
    end
  end
`endif
endmodule
